// File: rtl/display_frame_pkg.sv
// Shared constants, frame layout offsets and state type for the display frame transmitter.
package display_frame_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         FRAME_LEN = 64;

    localparam int OFF_SYNC   = 0;
    localparam int OFF_LED    = 1;
    localparam int OFF_SEG    = 2;
    localparam int OFF_LCD_A  = 3;
    localparam int OFF_LCD_B  = 11;
    localparam int OFF_INSTR  = 19;
    localparam int OFF_PC     = 23;
    localparam int OFF_SRCA   = 24;
    localparam int OFF_SRCB   = 25;
    localparam int OFF_ALU    = 26;
    localparam int OFF_RESULT = 27;
    localparam int OFF_WDATA  = 28;
    localparam int OFF_RDATA  = 29;
    localparam int OFF_FLAGS  = 30;
    localparam int OFF_REGS   = 31;
    localparam int OFF_CHK    = 63;

    typedef enum logic {
        IDLE,
        SEND
    } frame_state_t;

    // Byte k of an nbytes-wide field, counting from the most significant byte.
    function automatic logic [7:0] pick_byte(input logic [63:0] word, input int nbytes, input int k);
        return 8'(word >> (8 * (nbytes - 1 - k)));
    endfunction

endpackage

// File: rtl/display_frame_tx_if.sv
// Byte-wide valid/ready link from the frame transmitter toward the host adapter.
interface display_frame_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       frame_done;

    modport master (
        output tx_data,
        output tx_valid,
        output busy,
        output frame_done,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        input  busy,
        input  frame_done,
        output tx_ready
    );
endinterface

// File: rtl/display_frame_tx_byte_sel.sv
// Combinational frame layout: maps the captured snapshot and byte index to the frame byte.
module frame_byte_sel #(
    parameter int         NBITS_TOP   = 8,
    parameter int         NREGS_TOP   = 32,
    parameter int         NBITS_LCD   = 64,
    parameter int         NBITS_INSTR = 32,
    parameter logic [7:0] SYNC_VAL    = 8'hA5
) (
    input  logic [5:0]             idx,
    input  logic [NBITS_TOP-1:0]   led,
    input  logic [NBITS_TOP-1:0]   seg,
    input  logic [NBITS_LCD-1:0]   lcd_a,
    input  logic [NBITS_LCD-1:0]   lcd_b,
    input  logic [NBITS_INSTR-1:0] instr,
    input  logic [NBITS_TOP-1:0]   pc,
    input  logic [NBITS_TOP-1:0]   src_a,
    input  logic [NBITS_TOP-1:0]   src_b,
    input  logic [NBITS_TOP-1:0]   alu_result,
    input  logic [NBITS_TOP-1:0]   result,
    input  logic [NBITS_TOP-1:0]   write_data,
    input  logic [NBITS_TOP-1:0]   read_data,
    input  logic [3:0]             flags,
    input  logic [NBITS_TOP-1:0]   regs [0:NREGS_TOP-1],
    input  logic [7:0]             chk,
    output logic [7:0]             byte_out
);
    import display_frame_pkg::*;

    localparam int REG_W = $clog2(NREGS_TOP);

    logic [REG_W-1:0] reg_sel;

    assign reg_sel = REG_W'(idx - 6'(OFF_REGS));

    always_comb begin
        byte_out = 8'h00;
        if (idx == 6'(OFF_SYNC))
            byte_out = SYNC_VAL;
        else if (idx == 6'(OFF_LED))
            byte_out = 8'(led);
        else if (idx == 6'(OFF_SEG))
            byte_out = 8'(seg);
        else if (idx < 6'(OFF_LCD_B))
            byte_out = pick_byte(64'(lcd_a), 8, int'(idx) - OFF_LCD_A);
        else if (idx < 6'(OFF_INSTR))
            byte_out = pick_byte(64'(lcd_b), 8, int'(idx) - OFF_LCD_B);
        else if (idx < 6'(OFF_PC))
            byte_out = pick_byte(64'(instr), 4, int'(idx) - OFF_INSTR);
        else if (idx == 6'(OFF_PC))
            byte_out = 8'(pc);
        else if (idx == 6'(OFF_SRCA))
            byte_out = 8'(src_a);
        else if (idx == 6'(OFF_SRCB))
            byte_out = 8'(src_b);
        else if (idx == 6'(OFF_ALU))
            byte_out = 8'(alu_result);
        else if (idx == 6'(OFF_RESULT))
            byte_out = 8'(result);
        else if (idx == 6'(OFF_WDATA))
            byte_out = 8'(write_data);
        else if (idx == 6'(OFF_RDATA))
            byte_out = 8'(read_data);
        else if (idx == 6'(OFF_FLAGS))
            byte_out = {4'b0000, flags};
        else if (idx < 6'(OFF_CHK))
            byte_out = 8'(regs[reg_sel]);
        else
            byte_out = chk;
    end

endmodule

// File: rtl/display_frame_tx.sv
// Captures the board/LCD signals on request and streams them as a 64-byte frame
// (sync byte, fields, XOR checksum) over a valid/ready byte link.
module display_frame_tx #(
    parameter int         NBITS_TOP   = 8,
    parameter int         NREGS_TOP   = 32,
    parameter int         NBITS_LCD   = 64,
    parameter int         NBITS_INSTR = 32,
    parameter logic [7:0] SYNC_BYTE   = display_frame_pkg::SYNC_BYTE
) (
    input  logic                   clk_2,
    input  logic                   reset,
    input  logic                   start,
    input  logic [NBITS_TOP-1:0]   LED,
    input  logic [NBITS_TOP-1:0]   SEG,
    input  logic [NBITS_LCD-1:0]   lcd_a,
    input  logic [NBITS_LCD-1:0]   lcd_b,
    input  logic [NBITS_INSTR-1:0] lcd_instruction,
    input  logic [NBITS_TOP-1:0]   lcd_registrador [0:NREGS_TOP-1],
    input  logic [NBITS_TOP-1:0]   lcd_pc,
    input  logic [NBITS_TOP-1:0]   lcd_SrcA,
    input  logic [NBITS_TOP-1:0]   lcd_SrcB,
    input  logic [NBITS_TOP-1:0]   lcd_ALUResult,
    input  logic [NBITS_TOP-1:0]   lcd_Result,
    input  logic [NBITS_TOP-1:0]   lcd_WriteData,
    input  logic [NBITS_TOP-1:0]   lcd_ReadData,
    input  logic                   lcd_MemWrite,
    input  logic                   lcd_Branch,
    input  logic                   lcd_MemtoReg,
    input  logic                   lcd_RegWrite,
    display_frame_tx_if.master     link
);
    import display_frame_pkg::*;

    localparam logic [5:0] LAST_IDX = 6'(FRAME_LEN - 1);

    frame_state_t state_q, state_d;
    logic         capture;
    logic         hs;
    logic [5:0]   idx_q;
    logic [7:0]   chk_q;
    logic         frame_done_q;
    logic [7:0]   byte_cur;

    logic [NBITS_TOP-1:0]   snap_led, snap_seg;
    logic [NBITS_LCD-1:0]   snap_a, snap_b;
    logic [NBITS_INSTR-1:0] snap_instr;
    logic [NBITS_TOP-1:0]   snap_pc, snap_srca, snap_srcb, snap_alu;
    logic [NBITS_TOP-1:0]   snap_result, snap_wdata, snap_rdata;
    logic [3:0]             snap_flags;
    logic [NBITS_TOP-1:0]   snap_regs [0:NREGS_TOP-1];

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // start is only honoured in IDLE, so a request during a frame is dropped, not queued.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        hs      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    capture = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                hs = link.tx_ready;
                if (hs && idx_q == LAST_IDX)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            idx_q        <= '0;
            chk_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= hs && (idx_q == LAST_IDX);
            if (capture) begin
                idx_q <= '0;
                chk_q <= '0;
            end else if (hs) begin
                idx_q <= idx_q + 6'd1;
                chk_q <= chk_q ^ byte_cur;
            end
        end
    end

    // Snapshot is frozen for the whole frame so late input changes cannot tear it.
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            snap_led    <= '0;
            snap_seg    <= '0;
            snap_a      <= '0;
            snap_b      <= '0;
            snap_instr  <= '0;
            snap_pc     <= '0;
            snap_srca   <= '0;
            snap_srcb   <= '0;
            snap_alu    <= '0;
            snap_result <= '0;
            snap_wdata  <= '0;
            snap_rdata  <= '0;
            snap_flags  <= '0;
            for (int i = 0; i < NREGS_TOP; i++)
                snap_regs[i] <= '0;
        end else if (capture) begin
            snap_led    <= LED;
            snap_seg    <= SEG;
            snap_a      <= lcd_a;
            snap_b      <= lcd_b;
            snap_instr  <= lcd_instruction;
            snap_pc     <= lcd_pc;
            snap_srca   <= lcd_SrcA;
            snap_srcb   <= lcd_SrcB;
            snap_alu    <= lcd_ALUResult;
            snap_result <= lcd_Result;
            snap_wdata  <= lcd_WriteData;
            snap_rdata  <= lcd_ReadData;
            snap_flags  <= {lcd_MemWrite, lcd_Branch, lcd_MemtoReg, lcd_RegWrite};
            for (int i = 0; i < NREGS_TOP; i++)
                snap_regs[i] <= lcd_registrador[i];
        end
    end

    frame_byte_sel #(
        .NBITS_TOP   (NBITS_TOP),
        .NREGS_TOP   (NREGS_TOP),
        .NBITS_LCD   (NBITS_LCD),
        .NBITS_INSTR (NBITS_INSTR),
        .SYNC_VAL    (SYNC_BYTE)
    ) u_byte_sel (
        .idx        (idx_q),
        .led        (snap_led),
        .seg        (snap_seg),
        .lcd_a      (snap_a),
        .lcd_b      (snap_b),
        .instr      (snap_instr),
        .pc         (snap_pc),
        .src_a      (snap_srca),
        .src_b      (snap_srcb),
        .alu_result (snap_alu),
        .result     (snap_result),
        .write_data (snap_wdata),
        .read_data  (snap_rdata),
        .flags      (snap_flags),
        .regs       (snap_regs),
        .chk        (chk_q),
        .byte_out   (byte_cur)
    );

    assign link.tx_valid   = (state_q == SEND);
    assign link.busy       = (state_q == SEND);
    assign link.tx_data    = (state_q == SEND) ? byte_cur : 8'h00;
    assign link.frame_done = frame_done_q;

endmodule
